// File: rtl/issue_stall_ctrl_pkg.sv
// Shared opcode constants, state encoding and instruction-field helpers
// for the decode-stage issue controller.
package issue_stall_ctrl_pkg;

  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [5:0]  OP_BNE    = 6'h05;
  localparam logic [5:0]  OP_BGTZ   = 6'h07;
  localparam logic [5:0]  OP_ADDI   = 6'h08;
  localparam logic [5:0]  OP_LW     = 6'h23;
  localparam logic [5:0]  OP_SW     = 6'h2B;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
  endfunction

  // Register written by an already-issued instruction; 0 means "writes nothing".
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    if (is_branch(op) || op == OP_SW) return 5'd0;
    if (op == OP_ADDI || op == OP_LW) return instr[20:16];
    return instr[15:11];
  endfunction

  // Opcodes whose rt field is a destination or unused rather than a source.
  function automatic logic rs_only(input logic [5:0] op);
    return (op == OP_BGTZ) || (op == OP_ADDI) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/issue_stall_ctrl_if.sv
// Decode-stage issue bus: instruction in, issued instruction and enables out.
interface issue_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             hold;
  logic [31:0]      issue_instr;
  logic             pc_we;
  logic             ifid_we;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output instr_in, instr_valid, hold,
    input  issue_instr, pc_we, ifid_we, bubble, stall_cnt
  );

  modport slave (
    input  instr_in, instr_valid, hold,
    output issue_instr, pc_we, ifid_we, bubble, stall_cnt
  );
endinterface

// File: rtl/issue_stall_ctrl_hazard_detect.sv
// Combinational RAW / branch hazard check of the decoded instruction
// against the three most recently issued instructions.
module hazard_detect
  import issue_stall_ctrl_pkg::*;
(
  input  logic [31:0] curr,
  input  logic [31:0] prev1,
  input  logic [31:0] prev2,
  input  logic [31:0] prev3,
  output logic        hazard
);

  function automatic logic slot_hazard(input logic [31:0] cur, input logic [31:0] prev);
    logic [4:0] d;
    d = dest_reg(prev);
    if (is_branch(prev[31:26])) return 1'b1;
    if (d == 5'd0) return 1'b0;
    if (d == cur[25:21]) return 1'b1;
    return !rs_only(cur[31:26]) && (d == cur[20:16]);
  endfunction

  // Any older slot in conflict stalls the current instruction.
  always_comb begin
    hazard = slot_hazard(curr, prev1) | slot_hazard(curr, prev2) | slot_hazard(curr, prev3);
  end

endmodule

// File: rtl/issue_stall_ctrl.sv
// Decode-stage issue controller: tracks issued history, bubbles ID/EX on
// hazards while freezing PC and IF/ID, and counts bubble cycles.
//
// state | meaning
// RUN   | issuing normally; a hazard bubbles immediately
// STALL | bubbling until the hazard drains out of the history
module issue_stall_ctrl
  import issue_stall_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  issue_stall_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [31:0]      hist_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       bub_run_q;
  logic             hazard_raw, hazard;
  logic [31:0]      issue;
  logic             we, bubble;

  hazard_detect u_hazard (
    .curr   (bus.instr_in),
    .prev1  (hist_q[0]),
    .prev2  (hist_q[1]),
    .prev3  (hist_q[2]),
    .hazard (hazard_raw)
  );

  assign hazard = hazard_raw & bus.instr_valid;

  // Next state and issue outputs; reset and hold both force a quiet cycle.
  always_comb begin
    state_d = state_q;
    issue   = NOP_INSTR;
    we      = 1'b0;
    bubble  = 1'b0;
    if (!reset && !bus.hold) begin
      if (hazard) begin
        bubble  = 1'b1;
        state_d = STALL;
      end else begin
        issue   = bus.instr_valid ? bus.instr_in : NOP_INSTR;
        we      = 1'b1;
        state_d = RUN;
      end
    end
  end

  // State, history shift, saturating bubble counter and bubble-run length.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      bub_run_q <= '0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= NOP_INSTR;
    end else if (!bus.hold) begin
      state_q   <= state_d;
      hist_q[0] <= issue;
      for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
      if (bubble && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (!bubble)                bub_run_q <= '0;
      else if (bub_run_q != 2'd3) bub_run_q <= bub_run_q + 2'd1;
    end
  end

  // Bubbles shift in as NOPs, so a fourth consecutive bubble cannot happen.
  always_ff @(posedge clk) begin
    if (!reset && !bus.hold && bubble) assert (bub_run_q != 2'd3);
  end

  assign bus.issue_instr = issue;
  assign bus.pc_we       = we;
  assign bus.ifid_we     = we;
  assign bus.bubble      = bubble;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_issue_stall_ctrl.sv
// Bench for issue_stall_ctrl: directed instruction sequences, a reference
// model of the issue rules checked every cycle, and literal spot checks.
module tb_issue_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_stall_ctrl_if #(.CNT_W(16)) bus ();
  issue_stall_ctrl_if #(.CNT_W(3))  bus_s ();

  issue_stall_ctrl #(.DEPTH(3), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  issue_stall_ctrl #(.DEPTH(3), .CNT_W(3)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  localparam logic [31:0] ADD3  = 32'h0022_1820;
  localparam logic [31:0] ADD4  = 32'h0063_2020;
  localparam logic [31:0] LW5   = 32'h8C25_0000;
  localparam logic [31:0] ADD7  = 32'h0022_3820;
  localparam logic [31:0] ADD6  = 32'h00A0_3020;
  localparam logic [31:0] BEQ   = 32'h1022_0004;
  localparam logic [31:0] ADD8  = 32'h012A_4020;
  localparam logic [31:0] ADD0  = 32'h0022_0020;
  localparam logic [31:0] ADD4Z = 32'h0000_2020;
  localparam logic [31:0] ADD5  = 32'h0084_2820;
  localparam logic [31:0] ADD6B = 32'h00A5_3020;
  localparam logic [31:0] ADDI5 = 32'h2025_0001;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  logic [31:0] m_hist [3] = '{32'h0, 32'h0, 32'h0};
  int          m_cnt = 0;

  function automatic logic [4:0] m_dest(input logic [31:0] ins);
    case (ins[31:26])
      6'h04, 6'h05, 6'h07, 6'h2B: return 5'd0;
      6'h08, 6'h23:               return ins[20:16];
      default:                    return ins[15:11];
    endcase
  endfunction

  function automatic bit m_hazard(input logic [31:0] cur, input logic valid);
    bit uses_rt;
    if (!valid) return 1'b0;
    uses_rt = !(cur[31:26] inside {6'h07, 6'h08, 6'h23});
    foreach (m_hist[k]) begin
      if (m_hist[k][31:26] inside {6'h04, 6'h05, 6'h07}) return 1'b1;
      if (m_dest(m_hist[k]) != 5'd0 &&
          (m_dest(m_hist[k]) == cur[25:21] || (uses_rt && m_dest(m_hist[k]) == cur[20:16])))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_expect(output logic [31:0] e_issue, output logic e_we, output logic e_bub);
    e_issue = 32'h0;
    e_we    = 1'b0;
    e_bub   = 1'b0;
    if (!reset && !bus.hold) begin
      if (m_hazard(bus.instr_in, bus.instr_valid)) e_bub = 1'b1;
      else begin
        e_we    = 1'b1;
        e_issue = bus.instr_valid ? bus.instr_in : 32'h0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model state advances with the design clock.
  always @(posedge clk) begin
    logic [31:0] ei;
    logic ew, eb;
    m_expect(ei, ew, eb);
    if (reset) begin
      m_hist <= '{32'h0, 32'h0, 32'h0};
      m_cnt  <= 0;
    end else if (!bus.hold) begin
      m_hist <= '{ei, m_hist[0], m_hist[1]};
      if (eb) m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] ei;
    logic ew, eb;
    if (checking) begin
      m_expect(ei, ew, eb);
      chk("issue_instr", bus.issue_instr, ei);
      chk("pc_we", {31'd0, bus.pc_we}, {31'd0, ew});
      chk("ifid_we", {31'd0, bus.ifid_we}, {31'd0, ew});
      chk("bubble", {31'd0, bus.bubble}, {31'd0, eb});
      chk("stall_cnt", {16'd0, bus.stall_cnt}, m_cnt);
      chk("stall_cnt_w3", {29'd0, bus_s.stall_cnt}, (m_cnt > 7) ? 7 : m_cnt);
      chk("small_issue", bus_s.issue_instr, ei);
    end
  end

  task automatic drive(input logic [31:0] ins, input logic valid, input logic hld, input logic rst);
    bus.instr_in      = ins;
    bus.instr_valid   = valid;
    bus.hold          = hld;
    bus_s.instr_in    = ins;
    bus_s.instr_valid = valid;
    bus_s.hold        = hld;
    reset             = rst;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checking = 1'b1;
    // Reset for two cycles
    drive(32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_pc_we", {31'd0, bus.pc_we}, 32'd0);
    chk("rst_issue", bus.issue_instr, 32'h0);
    tick();
    tick();

    // First instruction with empty history
    drive(ADD3, 1'b1, 1'b0, 1'b0);
    chk("s1_issue", bus.issue_instr, ADD3);
    chk("s1_pc_we", {31'd0, bus.pc_we}, 32'd1);
    chk("s1_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    tick();

    // Distance-1 dependency: three bubbles
    drive(ADD4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("s2_bubble", {31'd0, bus.bubble}, 32'd1);
      tick();
    end
    chk("s2_issue", bus.issue_instr, ADD4);
    chk("s2_cnt", {16'd0, bus.stall_cnt}, 32'd3);
    tick();

    // Load-use at distance 2: two bubbles
    drive(LW5, 1'b1, 1'b0, 1'b0);
    chk("s3_lw", bus.issue_instr, LW5);
    tick();
    drive(ADD7, 1'b1, 1'b0, 1'b0);
    chk("s3_add7", {31'd0, bus.bubble}, 32'd0);
    tick();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("s3_bubble", {31'd0, bus.bubble}, 32'd1);
      tick();
    end
    chk("s3_issue", bus.issue_instr, ADD6);
    chk("s3_cnt", {16'd0, bus.stall_cnt}, 32'd5);
    tick();

    // Branch in history: three bubbles regardless of registers
    drive(BEQ, 1'b1, 1'b0, 1'b0);
    chk("s4_beq", bus.issue_instr, BEQ);
    tick();
    drive(ADD8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("s4_bubble", {31'd0, bus.bubble}, 32'd1);
      tick();
    end
    chk("s4_issue", bus.issue_instr, ADD8);
    chk("s4_cnt", {16'd0, bus.stall_cnt}, 32'd8);
    chk("s4_cnt_sat", {29'd0, bus_s.stall_cnt}, 32'd7);
    tick();

    // Hold in the middle of a stall
    drive(ADD3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD4, 1'b1, 1'b0, 1'b0);
    chk("s5_first_bubble", {31'd0, bus.bubble}, 32'd1);
    tick();
    drive(ADD4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("s5_hold_bubble", {31'd0, bus.bubble}, 32'd0);
      chk("s5_hold_pc_we", {31'd0, bus.pc_we}, 32'd0);
      chk("s5_hold_cnt", {16'd0, bus.stall_cnt}, 32'd9);
      tick();
    end
    drive(ADD4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("s5_bubble", {31'd0, bus.bubble}, 32'd1);
      tick();
    end
    chk("s5_issue", bus.issue_instr, ADD4);
    chk("s5_cnt", {16'd0, bus.stall_cnt}, 32'd11);
    tick();

    // Register 0 never creates a dependency
    drive(ADD0, 1'b1, 1'b0, 1'b0);
    chk("s6_add0", {31'd0, bus.bubble}, 32'd0);
    tick();
    drive(ADD4Z, 1'b1, 1'b0, 1'b0);
    chk("s6_zero_src", bus.issue_instr, ADD4Z);
    tick();

    // Reset while stalled
    drive(ADD5, 1'b1, 1'b0, 1'b0);
    chk("s6_stall", {31'd0, bus.bubble}, 32'd1);
    tick();
    drive(ADD5, 1'b1, 1'b0, 1'b1);
    chk("s6_rst_issue", bus.issue_instr, 32'h0);
    tick();
    drive(ADD5, 1'b1, 1'b0, 1'b0);
    chk("s6_after_rst", bus.issue_instr, ADD5);
    chk("s6_after_rst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    tick();

    // Invalid instruction never stalls and issues a NOP
    drive(ADD6B, 1'b0, 1'b0, 1'b0);
    chk("inv_bubble", {31'd0, bus.bubble}, 32'd0);
    chk("inv_issue", bus.issue_instr, 32'h0);
    tick();
    drive(ADD6B, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("inv_then_issue", bus.issue_instr, ADD6B);
    chk("inv_cnt", {16'd0, bus.stall_cnt}, 32'd2);
    tick();

    // Reset wins over hold; ADDI's rt is not a source
    drive(32'h0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(ADD5, 1'b1, 1'b0, 1'b0);
    chk("rh_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    tick();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    chk("addi_rt", bus.issue_instr, ADDI5);
    tick();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
